// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The master side (the pipeline stage) issues requests; the slave side
// (memory) returns the acknowledge and the load data.
interface mem_wb_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage of the 64-bit pipeline plus the MEM/WB register.
// Doubleword loads/stores go out over a req/ack bus; while an access waits
// for its ack the stage stalls the earlier pipeline stages.
// Optional feature macro MEM_TIMEOUT_EN: aborts an access that has waited
// TIMEOUT_CYCLES cycles without an ack and raises the sticky mem_err flag.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWrite_in,
    input  logic               MemtoReg_in,
    input  logic               MemWrite_in,
    input  logic [63:0]        AluOut_in,
    input  logic [63:0]        DataOut_in,
    input  logic [4:0]         Rd_in,
    mem_wb_stage_if.master     mem,
    output logic               stall,
    output logic               RegWrite_Out,
    output logic               MemtoReg_Out,
    output logic [63:0]        ReadData_Out,
    output logic [63:0]        AluOut_Out,
    output logic [4:0]         Rd_out,
    output logic               mem_err
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t      state_r;
    logic        hold_regwrite_r;
    logic        hold_load_r;
    logic        hold_we_r;
    logic [63:0] hold_addr_r;
    logic [63:0] hold_wdata_r;
    logic [4:0]  hold_rd_r;

    logic        is_mem_s;
    logic        is_load_s;
    logic        abort_s;
    logic        req_s;
    logic        we_s;
    logic [63:0] addr_s;
    logic [63:0] wdata_s;
    logic        stall_s;

    // A store wins when both MemtoReg and MemWrite are set, so it is not a load.
    assign is_mem_s  = MemtoReg_in | MemWrite_in;
    assign is_load_s = MemtoReg_in & ~MemWrite_in;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic        err_r;

    // The count compared is the number of WAIT cycles including this one.
    assign cnt_next_s = cnt_r + 16'd1;
    assign abort_s    = (state_r == ST_WAIT) & ~mem.mem_ack & ~reset &
                        (cnt_next_s == TIMEOUT_LIMIT);
    assign mem_err    = err_r;

    // WAIT-cycle counter (cleared on entry to WAIT) and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 16'd0;
            err_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && is_mem_s && !mem.mem_ack) begin
                cnt_r <= 16'd0;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_next_s;
            end else begin
                cnt_r <= cnt_r;
            end
            if (abort_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    assign abort_s = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Request and stall decode: from the live inputs in IDLE, from the held op in WAIT.
    always_comb begin
        req_s   = 1'b0;
        we_s    = 1'b0;
        addr_s  = 64'd0;
        wdata_s = 64'd0;
        stall_s = 1'b0;
        if (reset) begin
            req_s   = 1'b0;
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_mem_s) begin
                        req_s   = 1'b1;
                        we_s    = MemWrite_in;
                        addr_s  = AluOut_in;
                        wdata_s = DataOut_in;
                        stall_s = ~mem.mem_ack;
                    end else begin
                        req_s   = 1'b0;
                    end
                end
                ST_WAIT: begin
                    req_s   = 1'b1;
                    we_s    = hold_we_r;
                    addr_s  = hold_addr_r;
                    wdata_s = hold_wdata_r;
                    stall_s = ~mem.mem_ack & ~abort_s;
                end
                default: begin
                    req_s   = 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req   = req_s;
    assign mem.mem_we    = we_s;
    assign mem.mem_addr  = addr_s;
    assign mem.mem_wdata = wdata_s;
    assign stall         = stall_s;

    // FSM, captured-op registers and the MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            hold_regwrite_r <= 1'b0;
            hold_load_r     <= 1'b0;
            hold_we_r       <= 1'b0;
            hold_addr_r     <= 64'd0;
            hold_wdata_r    <= 64'd0;
            hold_rd_r       <= 5'd0;
            RegWrite_Out    <= 1'b0;
            MemtoReg_Out    <= 1'b0;
            ReadData_Out    <= 64'd0;
            AluOut_Out      <= 64'd0;
            Rd_out          <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!is_mem_s || mem.mem_ack) begin
                        // Non-memory op or zero-wait access completes now.
                        RegWrite_Out <= RegWrite_in;
                        MemtoReg_Out <= is_mem_s & is_load_s;
                        ReadData_Out <= (is_mem_s && is_load_s) ? mem.mem_rdata : 64'd0;
                        AluOut_Out   <= AluOut_in;
                        Rd_out       <= Rd_in;
                        state_r      <= ST_IDLE;
                    end else begin
                        // No ack yet: hold the op and emit a bubble.
                        hold_regwrite_r <= RegWrite_in;
                        hold_load_r     <= is_load_s;
                        hold_we_r       <= MemWrite_in;
                        hold_addr_r     <= AluOut_in;
                        hold_wdata_r    <= DataOut_in;
                        hold_rd_r       <= Rd_in;
                        RegWrite_Out    <= 1'b0;
                        MemtoReg_Out    <= 1'b0;
                        ReadData_Out    <= 64'd0;
                        AluOut_Out      <= 64'd0;
                        Rd_out          <= 5'd0;
                        state_r         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_ack) begin
                        RegWrite_Out <= hold_regwrite_r;
                        MemtoReg_Out <= hold_load_r;
                        ReadData_Out <= hold_load_r ? mem.mem_rdata : 64'd0;
                        AluOut_Out   <= hold_addr_r;
                        Rd_out       <= hold_rd_r;
                        state_r      <= ST_IDLE;
                    end else begin
                        RegWrite_Out <= 1'b0;
                        MemtoReg_Out <= 1'b0;
                        ReadData_Out <= 64'd0;
                        AluOut_Out   <= 64'd0;
                        Rd_out       <= 5'd0;
                        state_r      <= abort_s ? ST_IDLE : ST_WAIT;
                    end
                end
                default: begin
                    RegWrite_Out <= 1'b0;
                    MemtoReg_Out <= 1'b0;
                    ReadData_Out <= 64'd0;
                    AluOut_Out   <= 64'd0;
                    Rd_out       <= 5'd0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// ops with random ack delays, checked against a transaction-level model.
module tb_mem_wb_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 32'd4;
`else
    localparam int unsigned TO_CYCLES = 32'd255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        regwrite_in;
    logic        memtoreg_in;
    logic        memwrite_in;
    logic [63:0] aluout_in;
    logic [63:0] dataout_in;
    logic [4:0]  rd_in;
    logic        stall;
    logic        regwrite_out;
    logic        memtoreg_out;
    logic [63:0] readdata_out;
    logic [63:0] aluout_out;
    logic [4:0]  rd_out;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if mif ();

    mem_wb_stage #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite_in  (regwrite_in),
        .MemtoReg_in  (memtoreg_in),
        .MemWrite_in  (memwrite_in),
        .AluOut_in    (aluout_in),
        .DataOut_in   (dataout_in),
        .Rd_in        (rd_in),
        .mem          (mif),
        .stall        (stall),
        .RegWrite_Out (regwrite_out),
        .MemtoReg_Out (memtoreg_out),
        .ReadData_Out (readdata_out),
        .AluOut_Out   (aluout_out),
        .Rd_out       (rd_out),
        .mem_err      (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_up(input logic rw, input logic mt, input logic mw,
                            input logic [63:0] alu, input logic [63:0] data, input logic [4:0] rd);
        regwrite_in = rw;
        memtoreg_in = mt;
        memwrite_in = mw;
        aluout_in   = alu;
        dataout_in  = data;
        rd_in       = rd;
    endtask

    task automatic drive_garbage();
        drive_up(1'($urandom), 1'($urandom), 1'($urandom), rnd64(), rnd64(), 5'($urandom));
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_rw"},  64'(regwrite_out), 64'd0);
        chk({tag, "_mt"},  64'(memtoreg_out), 64'd0);
        chk({tag, "_rd"},  readdata_out,      64'd0);
        chk({tag, "_alu"}, aluout_out,        64'd0);
    endtask

    // One op, acked nwait cycles after its request first appears (memory ops
    // only). Expected results follow the stage's rules at transaction level.
    task automatic do_op(input logic rw, input logic mt, input logic mw,
                         input logic [63:0] alu, input logic [63:0] data, input logic [4:0] rd,
                         input int nwait, input logic [63:0] rdata);
        logic is_mem;
        logic ld;
        int   n;
        is_mem = mt | mw;
        ld     = mt & ~mw;
        n      = is_mem ? nwait : 0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k == 0) drive_up(rw, mt, mw, alu, data, rd);
            else        drive_garbage();
            mif.mem_ack   = is_mem ? (k == n) : 1'($urandom);
            mif.mem_rdata = (k == n) ? rdata : rnd64();
            #1;
            chk("req", 64'(mif.mem_req), 64'(is_mem));
            if (is_mem) begin
                chk("addr",  mif.mem_addr,      alu);
                chk("wdata", mif.mem_wdata,     data);
                chk("we",    64'(mif.mem_we),   64'(mw));
            end
            chk("stall", 64'(stall), 64'(is_mem && (k < n)));
            @(posedge clk);
            #1;
            if (k < n) begin
                chk_bubble("bubble");
            end else begin
                chk("wb_rw",  64'(regwrite_out), 64'(rw));
                chk("wb_mt",  64'(memtoreg_out), 64'(ld));
                chk("wb_rdata", readdata_out,    ld ? rdata : 64'd0);
                chk("wb_alu", aluout_out,        alu);
                chk("wb_rdn", 64'(rd_out),       64'(rd));
            end
        end
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        reset = 1'b1;
        drive_garbage();
        mif.mem_ack   = 1'($urandom);
        mif.mem_rdata = rnd64();
        #1;
        chk("rst_req",   64'(mif.mem_req), 64'd0);
        chk("rst_stall", 64'(stall),       64'd0);
        @(posedge clk);
        #1;
        chk_bubble("rst");
        chk("rst_rdn", 64'(rd_out),  64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
    endtask

    initial begin
        int maxw;
        int kind;
        reset = 1'b1;
        drive_garbage();
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rnd64();

        // Reset held for two cycles with random inputs.
        reset_cycle();
        reset_cycle();
        @(negedge clk);
        reset = 1'b0;

        // ALU passthrough, zero-wait load, 3-wait store, both-set is a store.
        do_op(1'b1, 1'b0, 1'b0, 64'h1234, rnd64(), 5'd5, 0, rnd64());
        do_op(1'b1, 1'b1, 1'b0, 64'h100, rnd64(), 5'd7, 0, 64'hDEAD_BEEF);
        do_op(1'b0, 1'b0, 1'b1, 64'h208, 64'hCAFE, 5'd0, 3, rnd64());
        do_op(1'b1, 1'b1, 1'b1, 64'h3F8, 64'h55AA, 5'd9, 1, rnd64());

        // Reset while in WAIT abandons the access.
        @(negedge clk);
        drive_up(1'b1, 1'b1, 1'b0, 64'h440, 64'd0, 5'd3);
        mif.mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_garbage();
        mif.mem_ack = 1'b0;
        @(posedge clk);
        reset_cycle();
        @(negedge clk);
        reset = 1'b0;
        do_op(1'b1, 1'b0, 1'b0, 64'h77, rnd64(), 5'd2, 0, rnd64());
        do_op(1'b1, 1'b1, 1'b0, 64'h880, rnd64(), 5'd4, 0, 64'h0123_4567_89AB_CDEF);

`ifdef MEM_TIMEOUT_EN
        maxw = 3;
        // Load with ack held low: five request cycles, abort on the fifth.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) drive_up(1'b1, 1'b1, 1'b0, 64'h900, 64'd0, 5'd6);
            else        drive_garbage();
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = rnd64();
            #1;
            chk("to_req",   64'(mif.mem_req),  64'd1);
            chk("to_addr",  mif.mem_addr,      64'h900);
            chk("to_stall", 64'(stall),        64'(k < 4));
            @(posedge clk);
            #1;
            chk_bubble("to_bubble");
            chk("to_err", 64'(mem_err), 64'(k == 4));
        end
        do_op(1'b1, 1'b0, 1'b0, 64'h55, rnd64(), 5'd8, 0, rnd64());
        chk("to_err_sticky", 64'(mem_err), 64'd1);
        reset_cycle();
        @(negedge clk);
        reset = 1'b0;
        // Ack arriving in the would-be abort cycle completes normally.
        do_op(1'b1, 1'b1, 1'b0, 64'hA00, rnd64(), 5'd11, 4, 64'hFEED_F00D);
        chk("to_ack_err", 64'(mem_err), 64'd0);
`else
        maxw = 6;
`endif

        // Randomized ops with random ack delays.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            do_op(1'($urandom), (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                  rnd64(), rnd64(), 5'($urandom), $urandom_range(0, maxw), rnd64());
        end

`ifndef MEM_TIMEOUT_EN
        chk("err_tied", 64'(mem_err), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
